// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: funct3 encodings,
// FSM state encoding and the default datapath width.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  // ST_FIX is the single sign-fixup / result-select cycle after the divide loop.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/WallaceTreeMultiplier.sv
// Combinational signed N x N multiplier: partial products reduced by
// layers of 3:2 carry-save compressors, then one final carry-propagate add.
module WallaceTreeMultiplier #(
  parameter int N = 33
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product
);

  localparam int W = 2 * N;
  localparam int R = N + 1;

  // The sign bit of b has negative weight: its row is ~(a<<(N-1)) plus a +1 row.
  function automatic logic [W-1:0] wallace(input logic [N-1:0] x_a, input logic [N-1:0] x_b);
    logic [W-1:0] rows [R];
    logic [W-1:0] a_ext;
    logic [W-1:0] x, y, z;
    int           cnt;
    a_ext = {{N{x_a[N-1]}}, x_a};
    for (int i = 0; i < N - 1; i++) begin
      rows[i] = x_b[i] ? (a_ext << i) : '0;
    end
    rows[N-1] = x_b[N-1] ? ~(a_ext << (N - 1)) : '0;
    rows[N]   = {{(W-1){1'b0}}, x_b[N-1]};
    cnt = R;
    for (int lvl = 0; lvl < 16; lvl++) begin
      if (cnt > 2) begin
        for (int j = 0; j < R; j += 3) begin
          if (j + 2 < cnt) begin
            x = rows[j];
            y = rows[j+1];
            z = rows[j+2];
            rows[2*(j/3)]   = x ^ y ^ z;
            rows[2*(j/3)+1] = ((x & y) | (x & z) | (y & z)) << 1;
          end else if (j < cnt) begin
            x = rows[j];
            y = (j + 1 < cnt) ? rows[j+1] : '0;
            rows[2*(j/3)]   = x;
            rows[2*(j/3)+1] = y;
          end
        end
        cnt = 2 * (cnt / 3) + (cnt % 3);
      end
    end
    return rows[0] + rows[1];
  endfunction

  assign product = wallace(a, b);

endmodule

// File: rtl/serial_divider.sv
// Unsigned restoring divider: one quotient bit per clock, XLEN iterations.
// done_o is registered and stays high until the next start.
module serial_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = $clog2(XLEN);

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic            fits;

  // quo_q starts as the dividend and is shifted out MSB-first while quotient bits shift in.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dsr_q};
    fits    = ~trial[XLEN];
    busy_d  = busy_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    if (start_i) begin
      busy_d = 1'b1;
      done_d = 1'b0;
      cnt_d  = CW'(XLEN - 1);
      rem_d  = '0;
      quo_d  = dividend_i;
      dsr_d  = divisor_i;
    end else if (busy_q) begin
      rem_d = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], fits};
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute-stage unit: Wallace-tree multiply plus serial restoring divide.
// Handshake: an op transfers on a rising edge where valid && ready are both high;
// out_valid/result are held until an edge with out_ready high.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int MUL_STAGES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output state_e          dbg_state
);

  localparam int N = XLEN + 1;

  state_e            state_q, state_d;
  funct3_e           f3_q, f3_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic              div0_q, div0_d;
  logic              mwait_q, mwait_d;
  logic [2*N-1:0]    prod_q, prod_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept;
  logic [N-1:0]      mul_a, mul_b;
  logic [2*N-1:0]    prod_c;
  logic [2*N-1:0]    mul_src;
  logic [XLEN-1:0]   mul_res;
  logic              in_signed_div;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_start, div_done;
  logic [XLEN-1:0]   div_quo, div_rem;
  logic              q_neg, r_neg;
  logic [XLEN-1:0]   fix_res;
  logic              unused_prod_hi;

  assign accept = (state_q == ST_IDLE) && in_valid;

  // rs1 is signed for every multiply except MULHU; rs2 only for MUL/MULH.
  assign mul_a = {(f3_q != F3_MULHU) & rs1_q[XLEN-1], rs1_q};
  assign mul_b = {((f3_q == F3_MUL) || (f3_q == F3_MULH)) & rs2_q[XLEN-1], rs2_q};

  WallaceTreeMultiplier #(.N(N)) u_mul (
    .a       (mul_a),
    .b       (mul_b),
    .product (prod_c)
  );

  assign mul_src        = (MUL_STAGES == 0) ? prod_c : prod_q;
  assign mul_res        = (f3_q == F3_MUL) ? mul_src[XLEN-1:0] : mul_src[2*XLEN-1:XLEN];
  assign unused_prod_hi = ^mul_src[2*N-1:2*XLEN];

  // Divider is loaded straight from the ports on the accept edge so the loop starts at once.
  assign in_signed_div = ~funct3[0];
  assign mag_a     = (in_signed_div && rs1[XLEN-1]) ? ('0 - rs1) : rs1;
  assign mag_b     = (in_signed_div && rs2[XLEN-1]) ? ('0 - rs2) : rs2;
  assign div_start = accept && funct3[2] && (rs2 != '0);

  serial_divider #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .dividend_i  (mag_a),
    .divisor_i   (mag_b),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Overflow (MIN / -1) falls out naturally: |MIN| / 1 = MIN with q_neg clear.
  assign q_neg = ~f3_q[0] & (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]);
  assign r_neg = ~f3_q[0] & rs1_q[XLEN-1];

  always_comb begin
    fix_res = '1;
    if (div0_q) begin
      fix_res = f3_q[1] ? rs1_q : '1;
    end else if (f3_q[1]) begin
      fix_res = r_neg ? ('0 - div_rem) : div_rem;
    end else begin
      fix_res = q_neg ? ('0 - div_quo) : div_quo;
    end
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    div0_d   = div0_q;
    mwait_d  = mwait_q;
    prod_d   = prod_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          f3_d    = funct3_e'(funct3);
          rs1_d   = rs1;
          rs2_d   = rs2;
          div0_d  = (rs2 == '0);
          mwait_d = 1'b0;
          state_d = funct3[2] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        prod_d = prod_c;
        if ((MUL_STAGES == 0) || mwait_q) begin
          result_d = mul_res;
          mwait_d  = 1'b0;
          state_d  = ST_DONE;
        end else begin
          mwait_d = 1'b1;
        end
      end
      ST_DIV: begin
        if (div0_q || div_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d = fix_res;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      f3_q     <= F3_MUL;
      rs1_q    <= '0;
      rs2_q    <= '0;
      div0_q   <= 1'b0;
      mwait_q  <= 1'b0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      div0_q   <= div0_d;
      mwait_q  <= mwait_d;
      prod_q   <= prod_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
